// File: rtl/alu_control_pkg.sv
// Shared encodings for the ALU-control path, also used by the main control unit and the ALU.
package alu_control_pkg;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ORI    = 2'b11;

    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic [2:0] op;
        logic       illegal;
    } alu_ctl_t;

    localparam alu_ctl_t ALU_CTL_RESET = '{op: ALU_ADD, illegal: 1'b0};

endpackage

// File: rtl/alu_control_decode.sv
// Combinational ALUOp/funct decode; unsupported R-type functs fall back to ADD and raise illegal.
module alu_control_decode
    import alu_control_pkg::*;
(
    input  logic [5:0] funct,
    input  logic [1:0] alu_op,
    output alu_ctl_t   ctl
);

    always_comb begin
        ctl = '{op: ALU_ADD, illegal: 1'b0};
        case (alu_op)
            ALUOP_MEM:    ctl.op = ALU_ADD;
            ALUOP_BRANCH: ctl.op = ALU_SUB;
            ALUOP_ORI:    ctl.op = ALU_OR;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD, FUNCT_ADDU: ctl.op = ALU_ADD;
                    FUNCT_SUB, FUNCT_SUBU: ctl.op = ALU_SUB;
                    FUNCT_AND:             ctl.op = ALU_AND;
                    FUNCT_OR:              ctl.op = ALU_OR;
                    FUNCT_SLT:             ctl.op = ALU_SLT;
                    default:               ctl = '{op: ALU_ADD, illegal: 1'b1};
                endcase
            end
            default: ctl = '{op: ALU_ADD, illegal: 1'b0};
        endcase
    end

endmodule

// File: rtl/alu_control.sv
// Registered ALU-control decoder: one-cycle latency from funct/ALUOp to saida/illegal.
module alu_control
    import alu_control_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] funct,
    input  logic [1:0] ALUOp,
    output logic [2:0] saida,
    output logic       illegal
);

    alu_ctl_t ctl_d;
    alu_ctl_t ctl_q;

    alu_control_decode u_decode (
        .funct  (funct),
        .alu_op (ALUOp),
        .ctl    (ctl_d)
    );

    always_ff @(posedge clock) begin
        if (reset) ctl_q <= ALU_CTL_RESET;
        else       ctl_q <= ctl_d;
    end

    assign saida   = ctl_q.op;
    assign illegal = ctl_q.illegal;

endmodule

// File: tb/tb_alu_control.sv
// Directed vector table plus hand sequences for hold and reset-timing corners of alu_control.
module tb_alu_control;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] funct;
    logic [1:0] ALUOp;
    logic [2:0] saida;
    logic       illegal;

    int n_applied = 0;
    int n_bad     = 0;

    typedef struct packed {
        logic       rst;
        logic [1:0] aluop;
        logic [5:0] fn;
        logic [2:0] exp_op;
        logic       exp_ill;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    alu_control dut (
        .clock   (clock),
        .reset   (reset),
        .funct   (funct),
        .ALUOp   (ALUOp),
        .saida   (saida),
        .illegal (illegal)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [2:0] es, input logic ei);
        n_applied++;
        if (saida !== es || illegal !== ei) begin
            n_bad++;
            $display("FAIL %s: got saida=%b illegal=%b, want saida=%b illegal=%b",
                     tag, saida, illegal, es, ei);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 2'b10, 6'b100010, 3'b010, 1'b0}; // reset wins over sub
        vecs[1]  = '{1'b0, 2'b10, 6'b100010, 3'b110, 1'b0};
        vecs[2]  = '{1'b0, 2'b10, 6'b100000, 3'b010, 1'b0};
        vecs[3]  = '{1'b0, 2'b10, 6'b100100, 3'b000, 1'b0};
        vecs[4]  = '{1'b0, 2'b10, 6'b100101, 3'b001, 1'b0};
        vecs[5]  = '{1'b0, 2'b10, 6'b101010, 3'b111, 1'b0};
        vecs[6]  = '{1'b0, 2'b10, 6'b100001, 3'b010, 1'b0};
        vecs[7]  = '{1'b0, 2'b10, 6'b100011, 3'b110, 1'b0};
        vecs[8]  = '{1'b0, 2'b10, 6'b100000, 3'b010, 1'b0};
        vecs[9]  = '{1'b0, 2'b01, 6'b100000, 3'b110, 1'b0};
        vecs[10] = '{1'b0, 2'b00, 6'b101010, 3'b010, 1'b0};
        vecs[11] = '{1'b0, 2'b00, 6'b000000, 3'b010, 1'b0};
        vecs[12] = '{1'b0, 2'b11, 6'b101010, 3'b001, 1'b0};
        vecs[13] = '{1'b0, 2'b11, 6'b000000, 3'b001, 1'b0};
        vecs[14] = '{1'b0, 2'b10, 6'b000000, 3'b010, 1'b1};
        vecs[15] = '{1'b0, 2'b10, 6'b111111, 3'b010, 1'b1};
        vecs[16] = '{1'b0, 2'b10, 6'b100101, 3'b001, 1'b0};
        vecs[17] = '{1'b0, 2'b10, 6'b100110, 3'b010, 1'b1};
        vecs[18] = '{1'b0, 2'b01, 6'b111111, 3'b110, 1'b0};
        vecs[19] = '{1'b0, 2'b11, 6'b111111, 3'b001, 1'b0};
        vecs[20] = '{1'b1, 2'b10, 6'b101010, 3'b010, 1'b0}; // reset on same edge as slt

        reset = 1'b0;
        ALUOp = 2'b00;
        funct = 6'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clock);
            reset = vecs[i].rst;
            ALUOp = vecs[i].aluop;
            funct = vecs[i].fn;
            @(posedge clock);
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp_op, vecs[i].exp_ill);
        end

        // Hold: inputs changed after an edge do not reach the outputs until the next edge.
        @(negedge clock);
        reset = 1'b0;
        ALUOp = 2'b10;
        funct = 6'b101010;
        @(posedge clock);
        #1;
        check("hold_load", 3'b111, 1'b0);
        funct = 6'b100100;
        #2;
        check("hold_mid", 3'b111, 1'b0);
        ALUOp = 2'b10;
        funct = 6'b111111;
        @(negedge clock);
        check("hold_neg", 3'b111, 1'b0);
        funct = 6'b100100;
        @(posedge clock);
        #1;
        check("hold_next", 3'b000, 1'b0);

        // Reset pulse that does not span an edge must be ignored.
        #1;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(negedge clock);
        check("rst_glitch_neg", 3'b000, 1'b0);
        @(posedge clock);
        #1;
        check("rst_glitch_edge", 3'b000, 1'b0);

        // Reset clears a pending illegal flag.
        @(negedge clock);
        funct = 6'b000111;
        @(posedge clock);
        #1;
        check("ill_set", 3'b010, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("ill_reset", 3'b010, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        ALUOp = 2'b01;
        @(posedge clock);
        #1;
        check("post_reset", 3'b110, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_bad);
        $finish;
    end

endmodule
